// File: rtl/plic_lite_if.sv
// Register bus between the core and plic_lite: byte address, byte-reversed data,
// one-cycle write/read strobes and combinational read data.
interface plic_lite_if;
  logic [15:0] a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;

  modport master (output a, d, we, rd, input spo);
  modport slave  (input a, d, we, rd, output spo);
endinterface

// File: rtl/plic_lite.sv
// Lite platform interrupt controller: synchronised level sources, per-source
// gateways, priority/threshold arbiter and a claim/complete register pair.
module plic_lite #(
  parameter int NSRC   = 7,
  parameter int PRIO_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  plic_lite_if.slave      bus,
  input  logic [NSRC-1:0] src,
  output logic            e_irq
);
  localparam int ID_W = $clog2(NSRC + 1);
  localparam logic [15:0] A_PEND  = 16'h1000;
  localparam logic [15:0] A_EN    = 16'h2000;
  localparam logic [15:0] A_THR   = 16'h3000;
  localparam logic [15:0] A_CLAIM = 16'h3004;

  // we and rd are single-cycle strobes qualified by a: a write commits on the
  // edge where we=1, spo is valid combinationally for whatever a holds, and rd
  // matters only because reading the claim register consumes the winning source.
  logic [31:0]       din;
  logic [31:0]       rdata;
  logic [NSRC:1]     sync1, sync2;
  logic [NSRC:1]     pend, pend_n;
  logic [NSRC:1]     claimed, claimed_n;
  logic [NSRC:1]     en;
  logic [PRIO_W-1:0] prio [1:NSRC];
  logic [PRIO_W-1:0] thr;
  logic [ID_W-1:0]   best;
  logic [PRIO_W-1:0] best_prio;
  logic              claim;
  logic              complete;
  logic [ID_W-1:0]   cid;
  logic              cid_hi_zero;

  assign din     = {bus.d[7:0], bus.d[15:8], bus.d[23:16], bus.d[31:24]};
  assign bus.spo = {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]};

  assign claim       = bus.rd && (bus.a == A_CLAIM);
  assign complete    = bus.we && (bus.a == A_CLAIM);
  assign cid         = din[ID_W-1:0];
  assign cid_hi_zero = (din[31:ID_W] == '0);

  // Scan from the highest ID down with >= so that an equal priority at a lower
  // ID replaces the current winner.
  always_comb begin
    best      = '0;
    best_prio = '0;
    for (int i = NSRC; i >= 1; i--) begin
      if (pend[i] && en[i] && (prio[i] > thr) && (prio[i] >= best_prio)) begin
        best      = ID_W'(i);
        best_prio = prio[i];
      end
    end
  end

  // A complete with an out-of-range ID matches no source and falls through.
  always_comb begin
    pend_n    = pend;
    claimed_n = claimed;
    for (int i = 1; i <= NSRC; i++) begin
      if (sync2[i] && !pend[i] && !claimed[i]) pend_n[i] = 1'b1;
      if (claim && (best == ID_W'(i))) begin
        pend_n[i]    = 1'b0;
        claimed_n[i] = 1'b1;
      end
      if (complete && cid_hi_zero && (cid == ID_W'(i))) claimed_n[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      pend    <= '0;
      claimed <= '0;
      e_irq   <= 1'b0;
    end else begin
      sync1   <= src;
      sync2   <= sync1;
      pend    <= pend_n;
      claimed <= claimed_n;
      e_irq   <= (best != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en  <= '0;
      thr <= '0;
      for (int i = 1; i <= NSRC; i++) prio[i] <= '0;
    end else if (bus.we) begin
      for (int i = 1; i <= NSRC; i++) begin
        if (bus.a == 16'(4 * i)) prio[i] <= din[PRIO_W-1:0];
      end
      if (bus.a == A_EN)  en  <= din[NSRC:1];
      if (bus.a == A_THR) thr <= din[PRIO_W-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.a)
      A_PEND:  rdata = 32'({pend, 1'b0});
      A_EN:    rdata = 32'({en, 1'b0});
      A_THR:   rdata = 32'(thr);
      A_CLAIM: rdata = 32'(best);
      default: begin
        for (int i = 1; i <= NSRC; i++) begin
          if (bus.a == 16'(4 * i)) rdata = 32'(prio[i]);
        end
      end
    endcase
  end
endmodule

// File: tb/tb_plic_lite.sv
// Self-checking bench for plic_lite: directed scenarios plus a randomized run
// compared against a rule-level reference model of the controller.
module tb_plic_lite;
  localparam int NSRC   = 7;
  localparam int PRIO_W = 3;

  logic            clk;
  logic            rst;
  logic [NSRC-1:0] src;
  logic            e_irq;
  logic [31:0]     v;
  logic [31:0]     exp_q[$];
  int              n_vec;
  int              n_err;
  bit              mon_on;

  plic_lite_if bus ();

  plic_lite #(.NSRC(NSRC), .PRIO_W(PRIO_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .src   (src),
    .e_irq (e_irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int          m_prio [1:NSRC];
  int          m_thr;
  bit [NSRC:0] m_pend, m_clm, m_en, m_s1, m_s2;
  bit          m_e;

  function automatic logic [31:0] rev32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic int model_best();
    int b = 0;
    int bp = 0;
    for (int id = 1; id <= NSRC; id++) begin
      if (m_pend[id] && m_en[id] && m_prio[id] > m_thr && m_prio[id] > bp) begin
        b  = id;
        bp = m_prio[id];
      end
    end
    return b;
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] addr);
    int ai = int'(addr);
    if (ai == 'h1000) return 32'(m_pend);
    if (ai == 'h2000) return 32'(m_en);
    if (ai == 'h3000) return 32'(m_thr);
    if (ai == 'h3004) return 32'(model_best());
    if (ai < 'h1000 && ai % 4 == 0 && ai / 4 >= 1 && ai / 4 <= NSRC) return 32'(m_prio[ai / 4]);
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 1; i <= NSRC; i++) m_prio[i] = 0;
    m_thr  = 0;
    m_pend = '0;
    m_clm  = '0;
    m_en   = '0;
    m_s1   = '0;
    m_s2   = '0;
    m_e    = 1'b0;
  endtask

  task automatic model_step();
    int          b;
    int          ai;
    logic [31:0] dv;
    bit [NSRC:0] np, nc;
    b  = model_best();
    np = m_pend;
    nc = m_clm;
    for (int id = 1; id <= NSRC; id++)
      if (m_s2[id] && !m_pend[id] && !m_clm[id]) np[id] = 1'b1;
    if (bus.rd && bus.a == 16'h3004 && b != 0) begin
      np[b] = 1'b0;
      nc[b] = 1'b1;
    end
    if (bus.we) begin
      dv = rev32(bus.d);
      ai = int'(bus.a);
      if (ai == 'h3004 && dv >= 1 && dv <= NSRC) nc[dv] = 1'b0;
      if (ai == 'h2000) begin
        m_en    = dv[NSRC:0];
        m_en[0] = 1'b0;
      end
      if (ai == 'h3000) m_thr = int'(dv[PRIO_W-1:0]);
      if (ai < 'h1000 && ai % 4 == 0 && ai / 4 >= 1 && ai / 4 <= NSRC)
        m_prio[ai / 4] = int'(dv[PRIO_W-1:0]);
    end
    m_pend = np;
    m_clm  = nc;
    m_e    = (b != 0);
    m_s2   = m_s1;
    m_s1   = {src, 1'b0};
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- scoreboard / checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && !rst) check("e_irq", {31'd0, e_irq}, {31'd0, m_e});
  end

  // ---------------- driver tasks ----------------
  task automatic bus_wr(input logic [15:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.a  = addr;
    bus.d  = rev32(data);
    bus.we = 1'b1;
    @(posedge clk);
    #1 bus.we = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.a  = addr;
    bus.rd = 1'b1;
    #1 data = rev32(bus.spo);
    check($sformatf("rd_%h", addr), data, model_read(addr));
    @(posedge clk);
    #1 bus.rd = 1'b0;
  endtask

  // Combinational read with no strobe and no clock advance.
  task automatic peek(input logic [15:0] addr, output logic [31:0] data);
    bus.a  = addr;
    bus.rd = 1'b0;
    #1 data = rev32(bus.spo);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    logic [31:0] r;
    @(negedge clk);
    #1 rst = 1'b1;
    src = '0;
    #1 check("rst_eirq", {31'd0, e_irq}, 32'd0);
    peek(16'h1000, r); check("rst_pend",  r, 32'd0);
    peek(16'h2000, r); check("rst_en",    r, 32'd0);
    peek(16'h3000, r); check("rst_thr",   r, 32'd0);
    peek(16'h3004, r); check("rst_claim", r, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec  = 0;
    n_err  = 0;
    mon_on = 1'b0;
    rst    = 1'b0;
    src    = '0;
    bus.a  = '0;
    bus.d  = '0;
    bus.we = 1'b0;
    bus.rd = 1'b0;
    do_reset();
    mon_on = 1'b1;

    // basic flow
    bus_wr(16'h000C, 32'd2);
    bus_wr(16'h2000, 32'h08);
    bus_wr(16'h3000, 32'd0);
    @(negedge clk); src = 7'b0000100;
    @(negedge clk); src = '0; peek(16'h1000, v); check("pend_e0", v, 32'h0);
    @(negedge clk); peek(16'h1000, v); check("pend_e1", v, 32'h0);
    check("eirq_e1", {31'd0, e_irq}, 32'd0);
    @(negedge clk); peek(16'h1000, v); check("pend_e2", v, 32'h08);
    check("eirq_e2", {31'd0, e_irq}, 32'd0);
    @(negedge clk); check("eirq_e3", {31'd0, e_irq}, 32'd1);
    bus_rd(16'h3004, v); check("claim_basic", v, 32'd3);
    @(negedge clk); peek(16'h1000, v); check("pend_after_claim", v, 32'h0);
    bus_wr(16'h3004, 32'd3);
    idle(3);
    @(negedge clk); peek(16'h1000, v); check("no_repend_low", v, 32'h0);

    // arbitration
    do_reset();
    bus_wr(16'h0004, 32'd2);
    bus_wr(16'h0008, 32'd5);
    bus_wr(16'h0010, 32'd5);
    bus_wr(16'h2000, 32'h16);
    bus_wr(16'h3000, 32'd0);
    @(negedge clk); src = 7'b0001011;
    @(negedge clk); src = '0;
    idle(3);
    @(negedge clk); peek(16'h1000, v); check("arb_pend", v, 32'h16);
    exp_q = {32'd2, 32'd4, 32'd1, 32'd0};
    while (exp_q.size() > 0) begin
      bus_rd(16'h3004, v);
      check("arb_claim", v, exp_q.pop_front());
    end
    @(negedge clk); peek(16'h1000, v); check("arb_pend_end", v, 32'h0);

    // threshold / enable
    do_reset();
    bus_wr(16'h0014, 32'd3);
    bus_wr(16'h2000, 32'h20);
    bus_wr(16'h3000, 32'd3);
    @(negedge clk); src = 7'b0010000;
    @(negedge clk); src = '0;
    idle(4);
    @(negedge clk); check("thr3_eirq", {31'd0, e_irq}, 32'd0);
    peek(16'h1000, v); check("thr_pend", v, 32'h20);
    bus_wr(16'h3000, 32'd2);
    @(negedge clk); check("thr2_eirq_k", {31'd0, e_irq}, 32'd0);
    @(negedge clk); check("thr2_eirq_k1", {31'd0, e_irq}, 32'd1);
    bus_wr(16'h2000, 32'h0);
    @(negedge clk); check("en0_eirq_k", {31'd0, e_irq}, 32'd1);
    @(negedge clk); check("en0_eirq_k1", {31'd0, e_irq}, 32'd0);
    peek(16'h1000, v); check("en0_pend_kept", v, 32'h20);

    // level re-trigger
    do_reset();
    bus_wr(16'h0004, 32'd1);
    bus_wr(16'h2000, 32'h02);
    bus_wr(16'h3000, 32'd0);
    src = 7'b0000001;
    idle(4);
    @(negedge clk); check("lvl_eirq", {31'd0, e_irq}, 32'd1);
    bus_rd(16'h3004, v); check("lvl_claim", v, 32'd1);
    bus_wr(16'h3004, 32'd1);
    @(negedge clk); peek(16'h1000, v); check("lvl_pend_k", v, 32'h0);
    @(negedge clk); peek(16'h1000, v); check("lvl_pend_k1", v, 32'h02);
    check("lvl_eirq_k1", {31'd0, e_irq}, 32'd0);
    @(negedge clk); check("lvl_eirq_k2", {31'd0, e_irq}, 32'd1);

    // invalid completes leave ID1 claimed
    bus_rd(16'h3004, v); check("inv_claim", v, 32'd1);
    bus_wr(16'h3004, 32'd6);
    bus_wr(16'h3004, 32'd0);
    bus_wr(16'h3004, 32'd40);
    bus_wr(16'h3004, 32'd9);
    idle(3);
    @(negedge clk); peek(16'h1000, v); check("inv_no_repend", v, 32'h0);
    check("inv_eirq", {31'd0, e_irq}, 32'd0);
    bus_wr(16'h3004, 32'd1);
    idle(2);
    @(negedge clk); peek(16'h1000, v); check("valid_repend", v, 32'h02);
    check("pre_rst_eirq", {31'd0, e_irq}, 32'd1);

    // reset mid-run with an interrupt outstanding
    do_reset();
    @(negedge clk); peek(16'h1000, v); check("post_rst_pend", v, 32'h0);

    // randomized run against the model
    for (int it = 0; it < 900; it++) begin
      int op;
      logic [31:0] data;
      if ($urandom_range(0, 3) == 0) src = NSRC'($urandom);
      op = $urandom_range(0, 40);
      if (op <= 5)
        bus_wr(16'(4 * $urandom_range(0, 9) + ($urandom_range(0, 7) == 0 ? 1 : 0)), $urandom);
      else if (op <= 8)
        bus_wr(16'h2000, $urandom);
      else if (op <= 11)
        bus_wr(16'h3000, 32'($urandom_range(0, 4)));
      else if (op <= 19)
        bus_rd(16'h3004, v);
      else if (op <= 25) begin
        data = 32'($urandom_range(0, 8));
        if ($urandom_range(0, 4) == 0) data = data | (32'd1 << $urandom_range(3, 31));
        bus_wr(16'h3004, data);
      end else if (op <= 31) begin
        case ($urandom_range(0, 3))
          0: bus_rd(16'h1000, v);
          1: bus_rd(16'h2000, v);
          2: bus_rd(16'h3000, v);
          default: bus_rd(16'(4 * $urandom_range(0, 9)), v);
        endcase
      end else if (op <= 35) begin
        @(negedge clk);
        peek(16'h1000, v);
        check("rnd_pend", v, model_read(16'h1000));
      end else if (op <= 37) begin
        bus_wr(16'h4000, $urandom);
        bus_rd(16'h1004, v);
      end else if (op <= 39)
        idle($urandom_range(1, 3));
      else
        do_reset();
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
